// File: rtl/disp_scan_mux_if.sv
// Digit sources, display controls and the multiplexed 7-segment drive of
// the calculator display scanner.
interface disp_scan_mux_if;
   logic [15:0] op1_digits;
   logic [15:0] op2_digits;
   logic [15:0] res_digits;
   logic [1:0]  src_sel;
   logic [2:0]  digit_cnt;
   logic        res_neg;
   logic        lzb_en;
   logic        blink_en;
   logic [1:0]  cursor;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   modport master (
      output op1_digits, op2_digits, res_digits, src_sel, digit_cnt,
             res_neg, lzb_en, blink_en, cursor,
      input  an, seg, dp
   );

   modport slave (
      input  op1_digits, op2_digits, res_digits, src_sel, digit_cnt,
             res_neg, lzb_en, blink_en, cursor,
      output an, seg, dp
   );
endinterface

// File: rtl/disp_scan_mux.sv
// 4-digit common-anode 7-segment scanner with per-frame source latching,
// entry/leading-zero/cursor blanking, sign point and anti-ghosting guard.
module disp_scan_mux #(
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD        = 16,
   parameter int BLINK_FRAMES = 64
) (
   input logic          clk,
   input logic          rst,
   disp_scan_mux_if.slave bus
);
   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [DIV_W-1:0] r_div_cnt;
   logic [1:0]       r_scan_idx;
   logic [FRM_W-1:0] r_frame_cnt;
   logic             r_blink_phase;

   logic [15:0] r_word;
   logic [1:0]  r_src_sel;
   logic [2:0]  r_digit_cnt;
   logic        r_res_neg;
   logic        r_lzb_en;
   logic        r_blink_en;
   logic [1:0]  r_cursor;

   logic [3:0] r_an;
   logic [6:0] r_seg;
   logic       r_dp;

   logic w_div_tc, w_scan_tc, w_frm_tc, w_frame_start;
   logic [15:0] w_live_word, w_word;
   logic [1:0]  w_src_sel, w_cursor;
   logic [2:0]  w_digit_cnt;
   logic        w_res_neg, w_lzb_en, w_blink_en;
   logic [3:0]  w_digit;
   logic [3:0]  w_lz;
   logic        w_blank;
   logic [6:0]  w_font;
   logic [3:0]  w_an_nxt;
   logic [6:0]  w_seg_nxt;
   logic        w_dp_nxt;

   assign w_div_tc      = (r_div_cnt == DIV_W'(REFRESH_DIV - 1));
   assign w_scan_tc     = (r_scan_idx == 2'd3);
   assign w_frm_tc      = (r_frame_cnt == FRM_W'(BLINK_FRAMES - 1));
   assign w_frame_start = (r_div_cnt == '0) && (r_scan_idx == 2'd0);

   always_comb begin
      w_live_word = bus.res_digits;
      case (bus.src_sel)
         2'd0:    w_live_word = bus.op1_digits;
         2'd1:    w_live_word = bus.op2_digits;
         default: w_live_word = bus.res_digits;
      endcase
   end

   // The frame-start cycle already displays with the values being latched.
   assign w_word      = w_frame_start ? w_live_word   : r_word;
   assign w_src_sel   = w_frame_start ? bus.src_sel   : r_src_sel;
   assign w_digit_cnt = w_frame_start ? bus.digit_cnt : r_digit_cnt;
   assign w_res_neg   = w_frame_start ? bus.res_neg   : r_res_neg;
   assign w_lzb_en    = w_frame_start ? bus.lzb_en    : r_lzb_en;
   assign w_blink_en  = w_frame_start ? bus.blink_en  : r_blink_en;
   assign w_cursor    = w_frame_start ? bus.cursor    : r_cursor;

   assign w_digit = w_word[{r_scan_idx, 2'b00} +: 4];
   assign w_lz[0] = (w_word[3:0] == 4'd0);
   assign w_lz[1] = w_lz[0] && (w_word[7:4] == 4'd0);
   assign w_lz[2] = w_lz[1] && (w_word[11:8] == 4'd0);
   assign w_lz[3] = 1'b0;

   assign w_blank = (w_src_sel == 2'd3)
                 || ((w_src_sel < 2'd2) && ({1'b0, r_scan_idx} >= w_digit_cnt))
                 || ((w_src_sel == 2'd2) && w_lzb_en && w_lz[r_scan_idx])
                 || (w_blink_en && r_blink_phase && (r_scan_idx == w_cursor));

   always_comb begin
      w_font = 7'h7F;
      case (w_digit)
         4'h0: w_font = 7'h40;
         4'h1: w_font = 7'h79;
         4'h2: w_font = 7'h24;
         4'h3: w_font = 7'h30;
         4'h4: w_font = 7'h19;
         4'h5: w_font = 7'h12;
         4'h6: w_font = 7'h02;
         4'h7: w_font = 7'h78;
         4'h8: w_font = 7'h00;
         4'h9: w_font = 7'h10;
         4'hA: w_font = 7'h08;
         4'hB: w_font = 7'h03;
         4'hC: w_font = 7'h46;
         4'hD: w_font = 7'h21;
         4'hE: w_font = 7'h06;
         4'hF: w_font = 7'h0E;
         default: w_font = 7'h7F;
      endcase
   end

   always_comb begin
      w_an_nxt  = 4'hF;
      w_seg_nxt = r_seg;
      w_dp_nxt  = r_dp;
      if (r_div_cnt >= DIV_W'(GUARD)) begin
         w_an_nxt  = ~(4'b1000 >> r_scan_idx);
         w_seg_nxt = w_blank ? 7'h7F : w_font;
         w_dp_nxt  = !((r_scan_idx == 2'd0) && (w_src_sel == 2'd2) && w_res_neg);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div_cnt     <= '0;
         r_scan_idx    <= 2'd0;
         r_frame_cnt   <= '0;
         r_blink_phase <= 1'b0;
         r_word        <= 16'h0000;
         r_src_sel     <= 2'd3;
         r_digit_cnt   <= 3'd0;
         r_res_neg     <= 1'b0;
         r_lzb_en      <= 1'b0;
         r_blink_en    <= 1'b0;
         r_cursor      <= 2'd0;
         r_an          <= 4'hF;
         r_seg         <= 7'h7F;
         r_dp          <= 1'b1;
      end else begin
         r_div_cnt <= w_div_tc ? '0 : r_div_cnt + 1'b1;
         if (w_div_tc) begin
            r_scan_idx <= r_scan_idx + 2'd1;
            if (w_scan_tc) begin
               r_frame_cnt <= w_frm_tc ? '0 : r_frame_cnt + 1'b1;
               if (w_frm_tc) r_blink_phase <= ~r_blink_phase;
            end
         end
         if (w_frame_start) begin
            r_word      <= w_live_word;
            r_src_sel   <= bus.src_sel;
            r_digit_cnt <= bus.digit_cnt;
            r_res_neg   <= bus.res_neg;
            r_lzb_en    <= bus.lzb_en;
            r_blink_en  <= bus.blink_en;
            r_cursor    <= bus.cursor;
         end
         r_an  <= w_an_nxt;
         r_seg <= w_seg_nxt;
         r_dp  <= w_dp_nxt;
      end
   end

   assign bus.an  = r_an;
   assign bus.seg = r_seg;
   assign bus.dp  = r_dp;
endmodule

// File: tb/tb_disp_scan_mux.sv
// Bench for disp_scan_mux with REFRESH_DIV=4, GUARD=1, BLINK_FRAMES=2:
// frame vectors from a table plus sequences for latching, blink and reset.
module tb_disp_scan_mux;
   logic clk = 1'b0;
   logic rst = 1'b1;

   disp_scan_mux_if dif();

   disp_scan_mux #(.REFRESH_DIV(4), .GUARD(1), .BLINK_FRAMES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] BL = 7'h7F;

   typedef struct packed {
      logic [1:0]       src;
      logic [15:0]      word;
      logic [2:0]       cnt;
      logic             neg;
      logic             lzb;
      logic [3:0][6:0]  exp_seg;
      logic             exp_dp0;
   } vec_t;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } obs_t;

   logic [6:0]      font [16];
   vec_t            vecs [10];
   obs_t            sb [$];
   int              t;
   int              checks;
   int              failures;
   logic [3:0][6:0] exp_seg;
   logic            exp_dp0;
   logic [6:0]      hold_seg;
   logic            hold_dp;

   function automatic logic [3:0][6:0] mk(input logic [6:0] s0, s1, s2, s3);
      return {s3, s2, s1, s0};
   endfunction

   // One clock: predict the registered outputs for cycle t, then compare.
   task automatic step(input string tag);
      obs_t e;
      obs_t a;
      int   dv;
      int   slot;
      dv   = t % 4;
      slot = (t / 4) % 4;
      if (dv < 1) begin
         e.an  = 4'hF;
         e.seg = hold_seg;
         e.dp  = hold_dp;
      end else begin
         e.an  = ~(4'b1000 >> slot);
         e.seg = exp_seg[slot];
         e.dp  = (slot == 0) ? exp_dp0 : 1'b1;
      end
      hold_seg = e.seg;
      hold_dp  = e.dp;
      sb.push_back(e);
      @(posedge clk);
      #1;
      t++;
      a = {dif.an, dif.seg, dif.dp};
      e = sb.pop_front();
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s cycle=%0d slot=%0d: an/seg/dp got %b/%h/%b expected %b/%h/%b",
                  tag, t - 1, slot, a.an, a.seg, a.dp, e.an, e.seg, e.dp);
      end
   endtask

   task automatic run_frame(input string tag);
      repeat (16) step(tag);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({dif.an, dif.seg, dif.dp} !== {4'hF, BL, 1'b1}) begin
         failures++;
         $display("FAIL %s: an/seg/dp got %b/%h/%b expected 1111/7f/1",
                  tag, dif.an, dif.seg, dif.dp);
      end
      rst      = 1'b0;
      t        = 0;
      hold_seg = BL;
      hold_dp  = 1'b1;
   endtask

   // Non-selected sources carry scrambled copies so a wrong mux shows up.
   task automatic set_vec(input vec_t v);
      dif.src_sel    = v.src;
      dif.op1_digits = (v.src == 2'd0) ? v.word : v.word ^ 16'h5A5A;
      dif.op2_digits = (v.src == 2'd1) ? v.word : v.word ^ 16'hA5A5;
      dif.res_digits = (v.src == 2'd2) ? v.word : v.word ^ 16'h3C3C;
      dif.digit_cnt  = v.cnt;
      dif.res_neg    = v.neg;
      dif.lzb_en     = v.lzb;
      exp_seg        = v.exp_seg;
      exp_dp0        = v.exp_dp0;
   endtask

   initial begin
      vec_t v;
      checks   = 0;
      failures = 0;
      t        = 0;
      font = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

      vecs[0] = '{2'd2, 16'h4321, 3'd0, 1'b0, 1'b0, mk(font[1], font[2], font[3], font[4]), 1'b1};
      vecs[1] = '{2'd0, 16'h0097, 3'd2, 1'b0, 1'b0, mk(font[7], font[9], BL, BL), 1'b1};
      vecs[2] = '{2'd2, 16'h5000, 3'd0, 1'b1, 1'b1, mk(BL, BL, BL, font[5]), 1'b0};
      vecs[3] = '{2'd2, 16'h0000, 3'd0, 1'b0, 1'b1, mk(BL, BL, BL, font[0]), 1'b1};
      vecs[4] = '{2'd1, 16'hFEDC, 3'd7, 1'b1, 1'b0, mk(font[12], font[13], font[14], font[15]), 1'b1};
      vecs[5] = '{2'd2, 16'h0A00, 3'd0, 1'b0, 1'b1, mk(BL, BL, font[10], font[0]), 1'b1};
      vecs[6] = '{2'd2, 16'h0806, 3'd0, 1'b1, 1'b1, mk(font[6], font[0], font[8], font[0]), 1'b0};
      vecs[7] = '{2'd0, 16'hBA98, 3'd0, 1'b1, 1'b0, mk(BL, BL, BL, BL), 1'b1};
      vecs[8] = '{2'd3, 16'h1234, 3'd4, 1'b1, 1'b0, mk(BL, BL, BL, BL), 1'b1};
      vecs[9] = '{2'd1, 16'h00B3, 3'd3, 1'b0, 1'b1, mk(font[3], font[11], font[0], BL), 1'b1};

      dif.blink_en = 1'b0;
      dif.cursor   = 2'd0;
      set_vec(vecs[8]);
      do_reset("reset");

      for (int i = 0; i < 10; i++) begin
         set_vec(vecs[i]);
         run_frame($sformatf("vec%0d", i));
      end

      // digit_cnt change mid-frame only shows up from the next frame
      v = '{2'd0, 16'h0097, 3'd2, 1'b0, 1'b0, mk(font[7], font[9], BL, BL), 1'b1};
      set_vec(v);
      fork
         run_frame("cnt_hold");
         begin
            repeat (8) @(posedge clk);
            #2 dif.digit_cnt = 3'd3;
         end
      join
      exp_seg[2] = font[0];
      run_frame("cnt_next");

      // cursor blink: phase flips every 2 frames counted from reset
      do_reset("reset_blink");
      v = '{2'd1, 16'h2468, 3'd4, 1'b0, 1'b0, mk(font[8], font[6], font[4], font[2]), 1'b1};
      dif.blink_en = 1'b1;
      dif.cursor   = 2'd2;
      for (int f = 0; f < 6; f++) begin
         set_vec(v);
         if (f == 2 || f == 3) exp_seg[2] = BL;
         run_frame($sformatf("blink_f%0d", f));
      end
      dif.blink_en = 1'b0;

      // reset in the middle of slot 2, then a fresh frame from slot 0
      set_vec(vecs[0]);
      repeat (10) step("pre_rst");
      do_reset("reset_mid");
      v = '{2'd2, 16'h8765, 3'd0, 1'b0, 1'b0, mk(font[5], font[6], font[7], font[8]), 1'b1};
      set_vec(v);
      run_frame("after_rst");

      // blank source latched while every input churns
      set_vec(vecs[8]);
      for (int c = 0; c < 32; c++) begin
         dif.op1_digits = 16'($urandom);
         dif.op2_digits = 16'($urandom);
         dif.res_digits = 16'($urandom);
         dif.digit_cnt  = 3'($urandom);
         dif.res_neg    = 1'($urandom);
         dif.lzb_en     = 1'($urandom);
         dif.blink_en   = 1'($urandom);
         dif.cursor     = 2'($urandom);
         dif.src_sel    = (t % 16 == 0) ? 2'd3 : 2'($urandom);
         step("blank_churn");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/disp_scan_mux.md
Name: disp_scan_mux

Overview:
- Read-side counterpart of the calculator operand/result storage.
- Takes the op1, op2 and result digit registers and drives a 4-digit, common-anode, multiplexed 7-segment display by time-division scanning.
- Adds digit-count blanking during entry, leading-zero blanking for results, cursor blink, sign indication and anti-ghosting guard time.
- Source data is sampled once per scan frame, so a frame never shows a mix of old and new values.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot (>= GUARD+2).
- GUARD, 16, cycles at start of each slot with all anodes off (< REFRESH_DIV).
- BLINK_FRAMES, 64, full scan frames per blink half-period (>= 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- op1_digits  in  16  {d3,d2,d1,d0}; d0 is the first-entered, most significant digit.
- op2_digits  in  16  same layout as op1_digits.
- res_digits  in  16  same layout as op1_digits.
- src_sel  in  2  0=op1, 1=op2, 2=result, 3=blank display.
- digit_cnt  in  3  valid entered digits, 0..4 (op1/op2 modes only); values above 4 are treated as 4.
- res_neg  in  1  result is negative.
- lzb_en  in  1  leading-zero blanking enable for result mode.
- blink_en  in  1  cursor blink enable.
- cursor  in  2  digit index (0..3) that blinks.
- an  out  4  anode enables, active-low; an[3] is the leftmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Counters:
  - div_cnt runs 0..REFRESH_DIV-1 and wraps.
  - When div_cnt is terminal, scan_idx advances 0..3 and wraps.
  - When scan_idx wraps 3->0, frame_cnt advances 0..BLINK_FRAMES-1; when frame_cnt wraps, blink_phase toggles.
- Frame latch: in the cycle where div_cnt==0 and scan_idx==0, latch the selected 16-bit digit word, src_sel, digit_cnt, res_neg, lzb_en, blink_en and cursor. Input changes at any other time take effect at the next frame start.
- Slot k drives anode an[3-k] with digit d_k.
- Guard: while div_cnt < GUARD, an=4'b1111; seg and dp hold their previous value.
- Blanking. Digit k is blank (seg=7'h7F) if any of these holds:
  - latched src_sel==3;
  - src_sel is 0 or 1 and k >= digit_cnt;
  - src_sel==2, lzb_en=1, k<3, and digits d0..dk are all 0 (d3 is never blanked);
  - blink_en=1, blink_phase=1 and k==cursor.
- A blanked slot still asserts its anode; only the segments are off.
- Font: full hex, 0-F, standard patterns. Example: 0 -> 7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110.
- dp: 0 (lit) only in slot 0 when latched src_sel==2 and res_neg=1; otherwise 1. Blanking does not suppress dp.
- Latency: an, seg and dp are registered, one cycle after the internal counter state they reflect.
- Reset:
  - an=4'b1111, seg=7'h7F, dp=1.
  - div_cnt=0, scan_idx=0, frame_cnt=0, blink_phase=0.
  - Latched src_sel=3.
  - The first cycle after rst deasserts is a frame-start latch cycle.
- Reset mid-frame aborts the scan immediately. Outputs reach reset values on the next edge, and no partial slot is completed.
- Simultaneous events: when the blink toggle and a frame latch land in the same cycle, the new frame uses the updated blink_phase.

Test Plan:
Bench parameters: REFRESH_DIV=4, GUARD=1, BLINK_FRAMES=2.
1. Reset, then src_sel=2, res_digits=16'h4321, lzb_en=0 -> slots 0..3 drive an=0111/1011/1101/1110 with seg for 1,2,3,4. Each slot is 1 guard cycle (an=1111) plus 3 active cycles; frame period is 16 cycles.
2. src_sel=0, op1_digits=16'h0097, digit_cnt=2 -> slot 0 shows 7 and slot 1 shows 9; slots 2 and 3 assert their anodes with seg=7F. Setting digit_cnt=3 mid-frame changes nothing until the next frame, then slot 2 shows 0.
3. src_sel=2, res_digits=16'h5000 (d0=d1=d2=0, d3=5), lzb_en=1, res_neg=1 -> slots 0..2 blank, slot 3 shows 5, dp=0 in slot 0 only. With res_digits=16'h0000, slot 3 shows 0.
4. src_sel=1, digit_cnt=4, blink_en=1, cursor=2 -> slot 2 shows its digit for frames 0-1, blank for frames 2-3, visible again for frames 4-5; other slots never blank.
5. Drive rst=1 in the middle of slot 2 -> next edge gives an=1111, seg=7F, dp=1. After release, scanning restarts at slot 0 with a fresh latch.
6. src_sel=3 with all inputs toggling every cycle -> seg stays 7F and dp stays 1 in every slot, while the anodes keep scanning.
